sync_frame_tx: RTL and testbench
================================

Name: sync_frame_tx

Overview:
Serial framed transmitter and the source side of the 1101 serial-detection path. It accepts a parallel payload word through a valid/ready handshake. It emits the 4-bit sync pattern 1101 on a single-bit serial line, then the payload MSB-first, then a quiet gap of zeros. It feeds the team's Moore 1101 sequence detectors and is also used as their stimulus source on the bench.

Parameters:
DATA_W, 8, payload width in bits; legal range 1..32.
GAP_CYCLES, 2, number of forced-zero cycles after the last payload bit; legal range 0..15.
SYNC_PAT, 4'b1101, sync header, sent MSB-first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  payload offered.
load_ready  output  1  block can accept a payload.
load_data  input  DATA_W  payload word; captured on transfer.
out  output  1  serial bit stream.
out_en  output  1  high while out carries a sync or payload bit.
sync_active  output  1  high while out carries a sync bit.
frame_done  output  1  one-cycle pulse at frame end.
frame_cnt  output  8  count of completed frames; wraps.

Behaviour:
- Timing convention: cycle c is the clock period that begins at posedge c. All outputs are registered or decoded from state registers. No combinational path from any input to any output.
- Reset (async, active-high):
  - state=IDLE, out=0, out_en=0, sync_active=0, frame_done=0, frame_cnt=0, load_ready=1.
  - Handshake is ignored while reset is high.
  - Reset mid-frame aborts the frame immediately. No frame_done pulse and no frame_cnt increment for the aborted frame.
- Transfer: occurs at posedge E when load_valid=1 and load_ready=1. load_data is latched into the shift register. Later changes on load_data have no effect on the frame in flight.
- FSM states: IDLE -> SYNC (4 cycles) -> DATA (DATA_W cycles) -> GAP (GAP_CYCLES cycles) -> IDLE.
  - GAP is skipped when GAP_CYCLES=0.
  - A down-counter, sized to max(DATA_W, GAP_CYCLES, 4), tracks the bits remaining in each state.
- IDLE:
  - load_ready=1, out=0, out_en=0, sync_active=0.
  - Transfer moves to SYNC at edge E.
- SYNC:
  - Cycles E..E+3. out = SYNC_PAT[3], [2], [1], [0] (1,1,0,1).
  - out_en=1, sync_active=1, load_ready=0.
- DATA:
  - Cycles E+4..E+3+DATA_W. out = load_data[DATA_W-1] down to load_data[0].
  - out_en=1, sync_active=0, load_ready=0.
- GAP:
  - Cycles E+4+DATA_W..E+3+DATA_W+GAP_CYCLES. out=0, out_en=0, load_ready=0.
  - Guarantees a zero-separated boundary for downstream non-overlapping detectors.
- frame_done:
  - High only in cycle E+4+DATA_W. This is the first GAP cycle, or the first IDLE cycle when GAP_CYCLES=0.
  - frame_cnt increments by 1 at the same edge; 255 -> 0 wrap, no saturation.
- Back-to-back frames:
  - load_ready returns to 1 in cycle E+4+DATA_W+GAP_CYCLES.
  - Earliest next transfer is posedge E+5+DATA_W+GAP_CYCLES. Minimum frame period is DATA_W+GAP_CYCLES+5 cycles (15 with defaults).
  - Exactly one mandatory IDLE cycle between frames.
- load_valid while load_ready=0: ignored; not queued, no side effects.
- The payload is sent unmodified: no stuffing, no scrambling. A payload containing 1101 is the consumer's concern.
- out is 0 whenever out_en is 0.

Test Plan:
1. Defaults, reset released, transfer 8'hA5 at posedge E -> out over cycles E..E+13 = 1,1,0,1,1,0,1,0,0,1,0,1,0,0. out_en high E..E+11 only; sync_active high E..E+3 only; frame_done high only in E+12; frame_cnt=1.
2. load_valid held high, load_data=8'h3C, switched to 8'hFF at E+2 -> first frame carries 3C. Second transfer at exactly E+15 carries FF. load_ready is low E..E+13 and high in E+14.
3. load_valid pulsed in cycles E+3 and E+10 of a frame -> no transfer, frame unchanged, frame_cnt still increments by exactly 1.
4. reset asserted asynchronously mid-payload (cycle E+7) -> out, out_en, sync_active, frame_done and frame_cnt drop to 0 at once; load_ready=1. After release, a new transfer of 8'h81 produces a clean 1101_10000001 frame.
5. 256 consecutive frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256; one frame_done pulse per frame.
6. Build with GAP_CYCLES=0, DATA_W=4, payload 4'h0, looped into a Moore non-overlapping 1101 detector model -> frame period 9 cycles. Detector output pulses exactly once per frame, in cycle E+4; frame_done is in E+8.

Source files
------------

// File: rtl/sync_frame_tx_if.sv
// Payload handshake between a word source and the serial framed transmitter.
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/sync_frame_tx.sv
// Framed serial transmitter: sends SYNC_PAT, then the payload MSB-first, then a zero gap.
// Every output is a flop, so nothing combinational reaches the pins from the handshake.
module sync_frame_tx #(
    parameter int         DATA_W     = 8,
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] SYNC_PAT   = 4'b1101
) (
    input  logic             clk,
    input  logic             reset,
    sync_frame_tx_if.slave   ld,
    output logic             out,
    output logic             out_en,
    output logic             sync_active,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);
    localparam int MAXC     = (DATA_W > GAP_CYCLES) ? ((DATA_W > 4) ? DATA_W : 4)
                                                    : ((GAP_CYCLES > 4) ? GAP_CYCLES : 4);
    localparam int CW       = $clog2(MAXC);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              out_q, out_d;
    logic              out_en_q, out_en_d;
    logic              sync_q, sync_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    // Outputs for the coming cycle are decoded from the next state, so each
    // bit appears in the cycle that starts at the edge that selects it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_d       = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ld.load_valid) begin
                    state_d = ST_SYNC;
                    cnt_d   = CW'(3);
                    shreg_d = ld.load_data;
                    out_d   = SYNC_PAT[3];
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = CW'(DATA_W - 1);
                    out_d   = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    out_d = SYNC_PAT[cnt_d[1:0]];
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = CW'(GAP_LOAD);
                    end
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    out_d   = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end
            end
            default: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
        endcase
        out_en_d = (state_d == ST_SYNC) || (state_d == ST_DATA);
        sync_d   = (state_d == ST_SYNC);
        ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_q       <= 1'b0;
            out_en_q    <= 1'b0;
            sync_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            out_en_q    <= out_en_d;
            sync_q      <= sync_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ld.load_ready = ready_q;
    assign out           = out_q;
    assign out_en        = out_en_q;
    assign sync_active   = sync_q;
    assign frame_done    = done_q;
    assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: default build (8-bit, gap 2) and a 4-bit gap-0 build
// feeding a behavioural Moore non-overlapping 1101 detector.
module tb_sync_frame_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sync_frame_tx_if #(.DATA_W(8)) a ();
    sync_frame_tx_if #(.DATA_W(4)) b ();

    logic       a_out, a_en, a_sync, a_done;
    logic [7:0] a_cnt;
    logic       b_out, b_en, b_sync, b_done;
    logic [7:0] b_cnt;

    sync_frame_tx u0 (
        .clk(clk), .reset(reset), .ld(a), .out(a_out), .out_en(a_en),
        .sync_active(a_sync), .frame_done(a_done), .frame_cnt(a_cnt)
    );
    sync_frame_tx #(.DATA_W(4), .GAP_CYCLES(0)) u6 (
        .clk(clk), .reset(reset), .ld(b), .out(b_out), .out_en(b_en),
        .sync_active(b_sync), .frame_done(b_done), .frame_cnt(b_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // Reference model: position of the current cycle inside a frame (-1 = idle).
    int          pos  [2];
    logic [31:0] mdata[2];
    logic [7:0]  mcnt [2];
    logic [3:0]  pat = 4'b1101;

    // Moore non-overlapping 1101 detector watching u6.
    logic [3:0] hist;
    logic       det_q, det_cycle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = -1; mdata[k] = '0; mcnt[k] = 8'd0;
        end
    endfunction

    function automatic void model_edge(int k, int dw, int g, logic v, logic [31:0] d);
        bit idle = (pos[k] < 0) || (pos[k] >= 4 + dw + g);
        if (idle) begin
            if (v) begin pos[k] = 0; mdata[k] = d; end
            else pos[k] = -1;
        end else pos[k]++;
        if (pos[k] == 4 + dw) mcnt[k]++;
    endfunction

    function automatic logic [12:0] model_exp(int k, int dw, int g);
        int   p = pos[k];
        logic o, en, sy, dn, rdy;
        rdy = (p < 0) || (p >= 4 + dw + g);
        sy  = (p >= 0) && (p < 4);
        en  = (p >= 0) && (p < 4 + dw);
        dn  = (p == 4 + dw);
        if (p < 0)            o = 1'b0;
        else if (p < 4)       o = pat[3-p];
        else if (p < 4 + dw)  o = mdata[k][dw-1-(p-4)];
        else                  o = 1'b0;
        return {o, en, sy, dn, rdy, mcnt[k]};
    endfunction

    task automatic step(input logic v, input logic [31:0] d);
        a.load_valid = v; a.load_data = d[7:0];
        b.load_valid = v; b.load_data = d[3:0];
        @(posedge clk);
        model_edge(0, 8, 2, v, d);
        model_edge(1, 4, 0, v, d);
        cyc++;
        @(negedge clk);
        chk("u0 model", {19'd0, a_out, a_en, a_sync, a_done, a.load_ready, a_cnt}, {19'd0, model_exp(0, 8, 2)});
        chk("u6 model", {19'd0, b_out, b_en, b_sync, b_done, b.load_ready, b_cnt}, {19'd0, model_exp(1, 4, 0)});
        det_cycle = det_q;
        hist = {hist[2:0], b_out};
        if (hist == 4'b1101) begin det_q = 1'b1; hist = 4'b0; end
        else det_q = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        hist = 4'b0; det_q = 1'b0; det_cycle = 1'b0;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o, en, sy, dn, rdy;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[15];

    initial begin
        logic [14:0] e_out, e_en, e_sy, e_dn, e_rdy;
        logic [11:0] bits81;
        int ndone, ndet, last_det, last_done, n5;
        logic [7:0] cnt_before;

        e_out = 15'b110110100101000;
        e_en  = 15'b111111111111000;
        e_sy  = 15'b111100000000000;
        e_dn  = 15'b000000000000100;
        e_rdy = 15'b000000000000001;
        for (int i = 0; i < 15; i++) begin
            tbl[i].v   = (i == 0);
            tbl[i].d   = (i == 0) ? 8'hA5 : 8'h00;
            tbl[i].o   = e_out[14-i];
            tbl[i].en  = e_en[14-i];
            tbl[i].sy  = e_sy[14-i];
            tbl[i].dn  = e_dn[14-i];
            tbl[i].rdy = e_rdy[14-i];
            tbl[i].cnt = (i >= 12) ? 8'd1 : 8'd0;
        end

        a.load_valid = 1'b0; a.load_data = '0;
        b.load_valid = 1'b0; b.load_data = '0;
        reset = 1'b1;
        model_reset();
        hist = 4'b0; det_q = 1'b0; det_cycle = 1'b0;
        @(negedge clk);
        chk("reset state u0", {19'd0, a_out, a_en, a_sync, a_done, a.load_ready, a_cnt}, {19'd0, 5'b00001, 8'd0});
        @(negedge clk);
        reset = 1'b0;

        // 1: single A5 frame from the vector table
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, {24'd0, tbl[i].d});
            chk("t1 table", {19'd0, a_out, a_en, a_sync, a_done, a.load_ready, a_cnt},
                {19'd0, tbl[i].o, tbl[i].en, tbl[i].sy, tbl[i].dn, tbl[i].rdy, tbl[i].cnt});
        end

        // 2: valid held, data switched mid-frame, back-to-back transfer at E+15
        for (int i = 0; i < 30; i++) begin
            step(1'b1, (i < 2) ? 32'h3C : 32'hFF);
            if (i < 15) chk("t2 ready", {31'd0, a.load_ready}, {31'd0, i == 14});
            if (i == 15) chk("t2 second sync", {31'd0, a_sync}, 32'd1);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0);

        // 3: load_valid pulses while busy are ignored
        cnt_before = a_cnt;
        step(1'b1, 32'h5A);
        for (int i = 1; i < 16; i++) step((i == 3) || (i == 10), $urandom);
        chk("t3 one frame", {24'd0, a_cnt}, {24'd0, cnt_before + 8'd1});

        // 4: async reset mid-payload, then a clean 81 frame
        step(1'b1, 32'h77);
        for (int i = 1; i < 8; i++) step(1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("t4 async reset", {19'd0, a_out, a_en, a_sync, a_done, a.load_ready, a_cnt}, {19'd0, 5'b00001, 8'd0});
        @(negedge clk);
        model_reset();
        hist = 4'b0; det_q = 1'b0; det_cycle = 1'b0;
        reset = 1'b0;
        bits81 = 12'b1101_10000001;
        for (int i = 0; i < 15; i++) begin
            step(i == 0, 32'h81);
            if (i < 12) chk("t4 81 bits", {30'd0, a_out, a_en}, {30'd0, bits81[11-i], 1'b1});
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) step($urandom_range(0, 2) == 0, $urandom);

        // 5: 256 frames, counter wrap
        do_reset();
        n5 = 0;
        for (int i = 0; i < 256 * 15 + 40 && n5 < 256; i++) begin
            step(1'b1, $urandom);
            if (a_done) begin
                n5++;
                if (n5 == 255) chk("t5 cnt 255", {24'd0, a_cnt}, 32'd255);
                if (n5 == 256) chk("t5 cnt wrap", {24'd0, a_cnt}, 32'd0);
            end
        end
        chk("t5 frames", n5, 256);

        // 6: gap-0 4-bit build into the 1101 detector
        do_reset();
        ndone = 0; ndet = 0; last_det = -100; last_done = 0;
        for (int i = 0; i < 58; i++) begin
            step(1'b1, 32'h0);
            if (det_cycle) begin ndet++; last_det = cyc; end
            if (b_done) begin
                ndone++;
                chk("t6 det lead", cyc - last_det, 4);
                if (ndone > 1) chk("t6 period", cyc - last_done, 9);
                last_done = cyc;
            end
        end
        chk("t6 frames", ndone, 6);
        chk("t6 det count", ndet, 6);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
